bit_scan_mux: RTL and testbench
===============================

BIT_SCAN_MUX -- requirements
Module: bit_scan_mux

Interface
REQ-001 Parameter NUM_IN, default 10: number of 1-bit input channels, range 2..16.
REQ-002 Parameter SEL_WIDTH, default 4: select/counter width; SHALL satisfy 2**SEL_WIDTH >= NUM_IN.
REQ-003 Parameter OUT_WIDTH, default 32: output word width, minimum 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_bits  input  NUM_IN  channel bits; bit i is channel i.
REQ-007 sel  input  SEL_WIDTH  channel select, used in direct mode only.
REQ-008 mode  input  1  0 = direct select, 1 = scan; sampled only as described below.
REQ-009 start  input  1  single-cycle request to begin a scan.
REQ-010 step  input  1  single-cycle advance strobe during a scan.
REQ-011 mux_out  output  OUT_WIDTH  selected bit in bit 0; bits OUT_WIDTH-1:1 always 0.
REQ-012 cur_sel  output  SEL_WIDTH  channel index currently presented on mux_out.
REQ-013 valid  output  1  one-cycle pulse when mux_out updates with a scanned channel.
REQ-014 busy  output  1  high while the scan state machine is in SCAN.
REQ-015 done  output  1  one-cycle pulse on completion of a scan.

Function
REQ-016 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-017 The state machine SHALL have exactly two states, IDLE and SCAN.
REQ-018 Direct mode: in IDLE with mode=0, mux_out[0] SHALL equal in_bits[sel] one cycle after sampling, and cur_sel SHALL equal the sampled sel.
REQ-019 Direct mode, sel >= NUM_IN: mux_out SHALL be all zero, and cur_sel SHALL still reflect sel.
REQ-020 valid and done SHALL never assert in direct mode.
REQ-021 IDLE->SCAN: on start=1 with mode=1, the block SHALL copy in_bits into an internal snapshot register, clear the scan counter to 0, and set busy the next cycle.
REQ-022 start with mode=0 SHALL be ignored, and direct mode SHALL continue.
REQ-023 If start and step are both high in IDLE, start SHALL take effect and step SHALL be ignored.
REQ-024 In SCAN, each step=1 SHALL, on the next edge, set mux_out[0]=snapshot[counter], cur_sel=counter, and valid=1, then increment the counter.
REQ-025 Cycles in SCAN without step SHALL hold mux_out and cur_sel, and valid SHALL be 0.
REQ-026 The step that presents channel NUM_IN-1 SHALL, in the same cycle as its valid, assert done, return the state to IDLE, drop busy, and wrap the counter to 0.
REQ-027 In SCAN, start, sel, mode and in_bits SHALL be ignored; the scan uses only the snapshot.
REQ-028 After a scan, mux_out and cur_sel SHALL hold the last scanned value until the first IDLE cycle.
REQ-029 From that first IDLE cycle onward, mux_out and cur_sel SHALL follow REQ-018 if mode=0.
REQ-030 Back-to-back scans SHALL be supported: start may be asserted on the cycle immediately after done.
REQ-031 A scan of NUM_IN channels SHALL need exactly NUM_IN step pulses; step latency to valid SHALL be 1 cycle.

Reset
REQ-032 On rst=1 at a clock edge, the state SHALL become IDLE and the counter SHALL be 0.
REQ-033 On rst=1, mux_out, cur_sel, valid, busy, done and the snapshot SHALL all be 0.
REQ-034 Reset SHALL take priority over start and step in the same cycle.
REQ-035 Reset mid-scan SHALL abandon the scan with no done pulse.

Verification
REQ-036 Direct mode: NUM_IN=10, in_bits=10'b10_0000_0101, sel sweeps 0..15 -> mux_out=1 for sel 0, 2, 9 and 0 otherwise, one cycle late; valid and done stay 0.
REQ-037 Scan: mode=1, start with in_bits=10'h2A5, then in_bits changed to 0, then 10 step pulses with gaps -> valid pulses with cur_sel 0..9 and bits 1,0,1,0,0,1,0,1,0,1; done coincides with the 10th valid; busy falls the same cycle.
REQ-038 Start and step both high in IDLE -> scan starts, counter=0, no valid that cycle; the next step presents channel 0.
REQ-039 Reset asserted after the 4th step -> next cycle all outputs 0, state IDLE, no done; a new start scans from channel 0.
REQ-040 Start asserted on the cycle after done -> a second full scan of 10 valids completes; start during SCAN does not restart the counter.
REQ-041 Parameter sweep NUM_IN=2/SEL_WIDTH=1/OUT_WIDTH=1 and NUM_IN=16/SEL_WIDTH=4/OUT_WIDTH=8 -> done after exactly NUM_IN steps; upper output bits stay 0.

Source files
------------

// File: rtl/bit_scan_mux.sv
// Single-bit channel multiplexer with a direct-select mode and a stepped scan mode.
// The scan mode latches a snapshot of every channel and presents one channel per step strobe.
module bit_scan_mux #(
  parameter int NUM_IN    = 10,
  parameter int SEL_WIDTH = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN-1:0]    in_bits,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 step,
  output logic [OUT_WIDTH-1:0] mux_out,
  output logic [SEL_WIDTH-1:0] cur_sel,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("bit_scan_mux: NUM_IN must be in 2..16");
  end
  if ((2 ** SEL_WIDTH) < NUM_IN) begin : g_bad_sel_width
    $error("bit_scan_mux: SEL_WIDTH too narrow for NUM_IN");
  end
  if (OUT_WIDTH < 1) begin : g_bad_out_width
    $error("bit_scan_mux: OUT_WIDTH must be at least 1");
  end

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [SEL_WIDTH-1:0] LAST_CH    = SEL_WIDTH'(NUM_IN - 1);
  localparam logic [SEL_WIDTH:0]   NUM_IN_EXT = (SEL_WIDTH + 1)'(NUM_IN);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] cur_sel_q, cur_sel_d;
  logic [NUM_IN-1:0]    snap_q, snap_d;
  logic                 bit_q, bit_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sel_in_range;

  // Out-of-range selects read as zero rather than indexing past in_bits.
  assign sel_in_range = ({1'b0, sel} < NUM_IN_EXT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    snap_d    = snap_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode) begin
          // start wins over a coincident step; the step is simply dropped
          if (start) begin
            snap_d  = in_bits;
            cnt_d   = '0;
            state_d = SCAN;
            busy_d  = 1'b1;
          end
        end else begin
          cur_sel_d = sel;
          bit_d     = sel_in_range ? in_bits[sel] : 1'b0;
        end
      end
      SCAN: begin
        if (step) begin
          bit_d     = snap_q[cnt_q];
          cur_sel_d = cnt_q;
          valid_d   = 1'b1;
          if (cnt_q == LAST_CH) begin
            done_d  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_sel_q <= '0;
      snap_q    <= '0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      snap_q    <= snap_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mux_out = OUT_WIDTH'(bit_q);
  assign cur_sel = cur_sel_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bit_scan_mux.sv
// Directed bench for bit_scan_mux: default instance plus two parameter corners.
module tb_bit_scan_mux;

  logic        clk;
  logic        rst, mode, start, step;
  logic [9:0]  in_bits;
  logic [3:0]  sel;
  logic [31:0] mux_out;
  logic [3:0]  cur_sel;
  logic        valid, busy, done;

  logic        p_rst, p_mode, p_start, p_step;
  logic [1:0]  p_in2;
  logic        p_sel1;
  logic        o2;
  logic        s2, v2, b2, d2;
  logic [15:0] p_in16;
  logic [3:0]  p_sel4;
  logic [7:0]  o16;
  logic [3:0]  s16;
  logic        v16, b16, d16;

  int total = 0;
  int bad   = 0;
  logic [9:0]  exp_bits;
  logic [15:0] in16c;
  logic [1:0]  in2c;

  bit_scan_mux dut (
    .clk(clk), .rst(rst), .in_bits(in_bits), .sel(sel), .mode(mode),
    .start(start), .step(step), .mux_out(mux_out), .cur_sel(cur_sel),
    .valid(valid), .busy(busy), .done(done)
  );

  bit_scan_mux #(.NUM_IN(2), .SEL_WIDTH(1), .OUT_WIDTH(1)) dut2 (
    .clk(clk), .rst(p_rst), .in_bits(p_in2), .sel(p_sel1), .mode(p_mode),
    .start(p_start), .step(p_step), .mux_out(o2), .cur_sel(s2),
    .valid(v2), .busy(b2), .done(d2)
  );

  bit_scan_mux #(.NUM_IN(16), .SEL_WIDTH(4), .OUT_WIDTH(8)) dut16 (
    .clk(clk), .rst(p_rst), .in_bits(p_in16), .sel(p_sel4), .mode(p_mode),
    .start(p_start), .step(p_step), .mux_out(o16), .cur_sel(s16),
    .valid(v16), .busy(b16), .done(d16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset must win over start/step and a live direct-mode select
    rst = 1'b1; mode = 1'b1; start = 1'b1; step = 1'b1; sel = 4'd5; in_bits = '1;
    p_rst = 1'b1; p_mode = 1'b0; p_start = 1'b0; p_step = 1'b0;
    p_in2 = '0; p_sel1 = 1'b0; p_in16 = '0; p_sel4 = '0;
    tick(); tick();
    chk("rst_mux", mux_out, 32'd0);
    chk("rst_sel", 32'(cur_sel), 32'd0);
    chk("rst_flags", {29'd0, valid, busy, done}, 32'd0);

    // direct-mode sweep; a start with mode=0 at sel 5 must be ignored
    rst = 1'b0; start = 1'b0; step = 1'b0; mode = 1'b0;
    in_bits = 10'b10_0000_0101;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      start = (s == 5);
      tick();
      chk("dir_mux", mux_out, 32'((s == 0) || (s == 2) || (s == 9)));
      chk("dir_sel", 32'(cur_sel), 32'(s));
      chk("dir_flags", {29'd0, valid, busy, done}, 32'd0);
    end
    start = 1'b0;

    // scan from a snapshot; live inputs are scrambled during the scan
    mode = 1'b1; in_bits = 10'h2A5; exp_bits = 10'h2A5; start = 1'b1;
    tick();
    start = 1'b0; in_bits = '0;
    chk("scan_start", {29'd0, busy, valid, done}, 32'b100);
    for (int i = 0; i < 10; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0; mode = 1'b0; sel = 4'd7; in_bits = '1;
      chk("scan_valid", 32'(valid), 32'd1);
      chk("scan_sel", 32'(cur_sel), 32'(i));
      chk("scan_bit", mux_out, 32'(exp_bits[i]));
      chk("scan_done", 32'(done), 32'(i == 9));
      chk("scan_busy", 32'(busy), 32'(i != 9));
      if (i < 9) begin
        tick();
        chk("scan_gap", {24'd0, valid, done, busy, 4'(cur_sel), mux_out[0]},
            {24'd0, 1'b0, 1'b0, 1'b1, 4'(i), exp_bits[i]});
      end
    end
    // first idle cycle after done resumes direct select
    tick();
    chk("post_mux", mux_out, 32'd1);
    chk("post_sel", 32'(cur_sel), 32'd7);
    chk("post_flags", {29'd0, valid, busy, done}, 32'd0);

    // start and step together: scan starts, no valid that cycle
    mode = 1'b1; in_bits = 10'h3FE; start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0; in_bits = '0;
    chk("ss_busy", 32'(busy), 32'd1);
    chk("ss_valid", {30'd0, valid, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      tick();
      chk("ss_sel", 32'(cur_sel), 32'(i));
      chk("ss_bit", mux_out, 32'(i != 0));
      chk("ss_vd", {30'd0, valid, done}, 32'b10);
    end
    // reset mid-scan, with step and start also high
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("mid_rst", {mux_out[7:0], 4'(cur_sel), valid, busy, done}, 32'd0);
    tick();
    step = 1'b0;
    chk("mid_rst_idle", {29'd0, valid, busy, done}, 32'd0);

    // two back-to-back scans; start mid-scan must not restart the counter
    exp_bits = 10'h155; in_bits = exp_bits; start = 1'b1;
    tick();
    start = 1'b0; in_bits = '0;
    for (int sc = 0; sc < 2; sc++) begin
      for (int i = 0; i < 10; i++) begin
        step = 1'b1; start = (i == 4);
        tick();
        chk("b2b_sel", 32'(cur_sel), 32'(i));
        chk("b2b_bit", mux_out, 32'(exp_bits[i]));
        chk("b2b_vd", {30'd0, valid, done}, {30'd0, 1'b1, 1'(i == 9)});
      end
      step = 1'b0; start = (sc == 0); in_bits = 10'h2AA;
      tick();
      start = 1'b0; in_bits = '0;
      chk("b2b_busy", 32'(busy), 32'(sc == 0));
      exp_bits = 10'h2AA;
    end

    // parameter corners driven with shared controls
    in16c = 16'hA5C3; in2c = 2'b10;
    p_rst = 1'b0; p_mode = 1'b1; p_in2 = in2c; p_in16 = in16c; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      p_step = 1'b1;
      tick();
      chk("p16_out", 32'(o16), {31'd0, in16c[i]});
      chk("p16_sel", 32'(s16), 32'(i));
      chk("p16_done", 32'(d16), 32'(i == 15));
      if (i < 2) chk("p2_out", 32'(o2), {31'd0, in2c[i]});
      chk("p2_vd", {30'd0, v2, d2}, {30'd0, 1'(i < 2), 1'(i == 1)});
    end
    p_step = 1'b0; p_mode = 1'b0; p_sel4 = 4'd15; p_sel1 = 1'b1;
    tick();
    chk("p16_dir", 32'(o16), 32'd1);
    chk("p2_dir", 32'(o2), 32'd1);
    chk("p_busy", {30'd0, b2, b16}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
